// File: rtl/uart_image_loader_pkg.sv
// Shared constants, pixel type and FSM state encodings for the UART image loader.
package uart_image_loader_pkg;

  localparam int unsigned DEF_CLK_FREQ   = 100_000_000;
  localparam int unsigned DEF_BAUD       = 115_200;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_RGB_WIDTH  = 24;
  localparam int unsigned DEF_FIFO_DEPTH = 2;
  localparam int unsigned DEF_IMG_WIDTH  = 8;
  localparam int unsigned DEF_IMG_HEIGHT = 10;
  localparam int unsigned DEF_MEM_SIZE   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  localparam int unsigned DEF_ADDR_W     = $clog2(DEF_MEM_SIZE);
  localparam logic [7:0]  DEF_SYNC_BYTE  = 8'hAA;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    ASM_SYNC,
    ASM_R,
    ASM_G,
    ASM_B
  } asm_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_e;

  // Clock cycles per 16x oversampling tick.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_image_loader_byte_rx.sv
// 8N1 UART byte receiver: rx synchronizer, 16x oversampling tick, bit FSM.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a low level
// RX_START     | counting to mid start bit to confirm it is still low
// RX_DATA      | sampling data bits every 16 ticks, LSB first
// RX_STOP      | waiting for mid stop bit; high = good byte
// RX_WAIT_HIGH | framing error, byte dropped, waiting for line high
module uart_byte_rx
  import uart_image_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int unsigned DIV    = baud_div(CLK_FREQ, BAUD);
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic                  rx_s1_q, rx_s2_q;
  logic [15:0]           div_cnt_q;
  logic                  tick;
  rx_state_e             state_q, state_d;
  logic [3:0]            tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  valid_q, valid_d;

  // Two-flop synchronizer; line resets to its idle-high level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Free-running down-counter; oversampling tick on terminal count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                div_cnt_q <= DIV_M1;
    else if (div_cnt_q == '0)   div_cnt_q <= DIV_M1;
    else                        div_cnt_q <= div_cnt_q - 16'd1;
  end

  assign tick = (div_cnt_q == '0);

  // Receiver state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RX_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
    end
  end

  // Bit-level sequencing; a good byte is flagged in the mid-stop cycle.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    valid_d    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          state_d    = RX_START;
          tick_cnt_d = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d = {rx_s2_q, shift_q[DATA_WIDTH-1:1]};
            if (bit_cnt_q == LAST_BIT) state_d = RX_STOP;
            else                       bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            if (rx_s2_q) begin
              valid_d = 1'b1;
              state_d = RX_IDLE;
            end else begin
              state_d = RX_WAIT_HIGH;
            end
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign valid_o = valid_q;
  assign data_o  = shift_q;

endmodule

// File: rtl/uart_image_loader.sv
// UART image loader: byte FIFO, SYNC/R/G/B pixel assembler, frame RAM and
// one-shot frame readout as a pixel stream with data-enable.
//
// state    | meaning
// ASM_SYNC | waiting for the frame-start marker (all bytes dropped in camera mode)
// ASM_R    | next byte is the red channel
// ASM_G    | next byte is the green channel
// ASM_B    | next byte is blue; writes the pixel to RAM
// RD_IDLE  | no readout in progress
// RD_READ  | reading RAM addresses 0..MEM_SIZE-1, one per cycle
module uart_image_loader
  import uart_image_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RGB_WIDTH  = DEF_RGB_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  cam_mode,
  output logic                  rx_done,
  output logic                  frame_done,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] r_port,
  output logic [DATA_WIDTH-1:0] g_port,
  output logic [DATA_WIDTH-1:0] b_port
);

  localparam int unsigned MEM_SIZE = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned ADDR_W   = $clog2(MEM_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);

  logic                  byte_valid;
  logic [DATA_WIDTH-1:0] byte_data;

  uart_byte_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_byte_rx (
    .clk_i  (clk),
    .rst_ni (reset),
    .rx_i   (rx),
    .valid_o(byte_valid),
    .data_o (byte_data)
  );

  assign rx_done = byte_valid;

  // ---------------- receive FIFO (first-word fall-through) ----------------
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      fifo_cnt_q;
  logic                  fifo_full, fifo_empty, push, pop;
  logic [DATA_WIDTH-1:0] fifo_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = byte_valid && !fifo_full;
  assign pop        = !fifo_empty;
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  // FIFO pointers and occupancy; a byte arriving while full is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage, not reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= byte_data;
  end

  // ---------------- pixel assembler ----------------
  asm_state_e            asm_q, asm_d;
  logic [7:0]            r_q, r_d, g_q, g_d;
  logic [ADDR_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  rgb_t                  wdata_q, wdata_d;
  logic                  frame_done_q, frame_done_d;

  // Assembler registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q        <= ASM_SYNC;
      r_q          <= '0;
      g_q          <= '0;
      pix_cnt_q    <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      r_q          <= r_d;
      g_q          <= g_d;
      pix_cnt_q    <= pix_cnt_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      frame_done_q <= frame_done_d;
    end
  end

  // One byte consumed per cycle; the B byte issues the RAM write.
  always_comb begin
    asm_d        = asm_q;
    r_d          = r_q;
    g_d          = g_q;
    pix_cnt_d    = pix_cnt_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    frame_done_d = 1'b0;
    if (pop) begin
      unique case (asm_q)
        ASM_SYNC: begin
          if (!cam_mode && fifo_head == SYNC_BYTE) asm_d = ASM_R;
        end
        ASM_R: begin
          r_d   = fifo_head;
          asm_d = ASM_G;
        end
        ASM_G: begin
          g_d   = fifo_head;
          asm_d = ASM_B;
        end
        ASM_B: begin
          we_d    = 1'b1;
          waddr_d = pix_cnt_q;
          wdata_d = '{r: r_q, g: g_q, b: fifo_head};
          if (pix_cnt_q == LAST_ADDR) begin
            frame_done_d = 1'b1;
            pix_cnt_d    = '0;
            asm_d        = ASM_SYNC;
          end else begin
            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
            asm_d     = ASM_R;
          end
        end
        default: asm_d = ASM_SYNC;
      endcase
    end
  end

  assign frame_done = frame_done_q;

  // ---------------- frame RAM ----------------
  logic [RGB_WIDTH-1:0] ram_q [MEM_SIZE];
  logic [RGB_WIDTH-1:0] rdata_q;
  rgb_t                 rd_pix;
  logic                 rd_en;
  logic [ADDR_W-1:0]    raddr_q, raddr_d;

  // Simple dual-port RAM: synchronous write, registered read gated by rd_en.
  always_ff @(posedge clk) begin
    if (we_q)  ram_q[waddr_q] <= wdata_q;
    if (rd_en) rdata_q <= ram_q[raddr_q];
  end

  assign rd_pix = rdata_q;

  // ---------------- frame reader ----------------
  rd_state_e rd_q, rd_d;
  logic      o_de_q;

  // Reader registers; entering READ is the frame_done-delayed start strobe,
  // so the first read follows the last RAM write by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= RD_IDLE;
      raddr_q <= '0;
      o_de_q  <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      raddr_q <= raddr_d;
      o_de_q  <= rd_en;
    end
  end

  // Sweep every address once per completed frame; restarts are ignored mid-sweep.
  always_comb begin
    rd_d    = rd_q;
    raddr_d = raddr_q;
    rd_en   = (rd_q == RD_READ);
    unique case (rd_q)
      RD_IDLE: begin
        if (frame_done_q) begin
          rd_d    = RD_READ;
          raddr_d = '0;
        end
      end
      RD_READ: begin
        if (raddr_q == LAST_ADDR) rd_d = RD_IDLE;
        else                      raddr_d = raddr_q + ADDR_W'(1);
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  assign o_de   = o_de_q;
  assign r_port = o_de_q ? rd_pix.r : '0;
  assign g_port = o_de_q ? rd_pix.g : '0;
  assign b_port = o_de_q ? rd_pix.b : '0;

endmodule

// File: tb/tb_uart_image_loader.sv
// Self-checking bench for uart_image_loader with a reduced 4x5 frame and a
// one-clock oversampling tick so whole frames fit in a short run.
module tb_uart_image_loader;

  localparam int unsigned CLK_FREQ = 1_843_200;
  localparam int unsigned BAUD     = 115_200;
  localparam int unsigned IMG_W    = 4;
  localparam int unsigned IMG_H    = 5;
  localparam int          MEM      = IMG_W * IMG_H;
  localparam int          BIT_CLKS = 16 * (CLK_FREQ / (BAUD * 16));

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       cam_mode = 1'b0;
  logic       rx_done, frame_done, o_de;
  logic [7:0] r_port, g_port, b_port;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_image_loader #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .IMG_WIDTH (IMG_W),
    .IMG_HEIGHT(IMG_H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .cam_mode  (cam_mode),
    .rx_done   (rx_done),
    .frame_done(frame_done),
    .o_de      (o_de),
    .r_port    (r_port),
    .g_port    (g_port),
    .b_port    (b_port)
  );

  // ---------------- output monitor (samples on falling edge) ----------------
  int          cyc = 0;
  int          n_rx = 0;
  int          n_nz = 0;
  int          fd_cyc[$];
  int          de_cyc[$];
  logic [23:0] de_pix[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done === 1'b1) n_rx++;
    if (frame_done === 1'b1) fd_cyc.push_back(cyc);
    if (o_de === 1'b1) begin
      de_cyc.push_back(cyc);
      de_pix.push_back({r_port, g_port, b_port});
    end else if ({r_port, g_port, b_port} !== 24'h0) begin
      n_nz++;
    end
  end

  // ---------------- reference model: bytes -> frames ----------------
  logic [23:0] m_mem [MEM];
  bit          m_in = 1'b0;
  int          m_pix = 0;
  int          m_rx = 0;
  int          m_fd = 0;
  logic [7:0]  m_tri[$];

  function automatic void model_byte(input logic [7:0] b);
    m_rx++;
    if (!m_in) begin
      if (b == 8'hAA && !cam_mode) begin
        m_in = 1'b1;
        m_tri.delete();
      end
    end else begin
      m_tri.push_back(b);
      if (m_tri.size() == 3) begin
        m_mem[m_pix] = {m_tri[0], m_tri[1], m_tri[2]};
        m_tri.delete();
        m_pix++;
        if (m_pix == MEM) begin
          m_fd++;
          m_in  = 1'b0;
          m_pix = 0;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    m_in  = 1'b0;
    m_pix = 0;
    m_tri.delete();
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_bits(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b1);
    model_byte(b);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    fd_cyc.delete();
    de_cyc.delete();
    de_pix.delete();
    n_nz = 0;
  endtask

  // Waits (bounded) for one full readout and compares it to the model frame.
  task automatic check_readout(input string tag);
    int waited = 0;
    int mism   = 0;
    int lat, span;
    logic [23:0] first_p, last_p;
    while (de_pix.size() < MEM && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    repeat (5) @(negedge clk);
    check({tag, "_fd_count"}, fd_cyc.size(), 1);
    check({tag, "_de_count"}, de_pix.size(), MEM);
    lat  = (fd_cyc.size() > 0 && de_cyc.size() > 0) ? de_cyc[0] - fd_cyc[0] : -1;
    span = (de_cyc.size() > 0) ? de_cyc[de_cyc.size()-1] - de_cyc[0] : -1;
    check({tag, "_de_latency"}, lat, 2);
    check({tag, "_de_contiguous"}, span, MEM - 1);
    for (int i = 0; i < MEM; i++) begin
      if (i >= de_pix.size() || de_pix[i] !== m_mem[i]) mism++;
    end
    check({tag, "_pixel_mismatches"}, mism, 0);
    first_p = (de_pix.size() > 0) ? de_pix[0] : 24'hxxxxxx;
    last_p  = (de_pix.size() > 0) ? de_pix[de_pix.size()-1] : 24'hxxxxxx;
    check({tag, "_first_pixel"}, first_p, m_mem[0]);
    check({tag, "_last_pixel"}, last_p, m_mem[MEM-1]);
    check({tag, "_rgb_zero_outside_de"}, n_nz, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rx0, fd0;
    logic [7:0] b;

    // Reset state
    repeat (5) @(negedge clk);
    check("reset_outputs", {rx_done, frame_done, o_de, r_port, g_port, b_port}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_outputs", {rx_done, frame_done, o_de, r_port, g_port, b_port}, 0);

    // Full frame: marker then ramp 0x00..0x3B
    clear_mon();
    rx0 = n_rx; fd0 = m_fd;
    send_byte(8'hAA);
    for (int i = 0; i < 3 * MEM; i++) send_byte(8'(i));
    check("full_rx_done_count", n_rx - rx0, m_rx - (m_rx - (3 * MEM + 1)) );
    check("full_model_frames", m_fd - fd0, fd_cyc.size());
    check_readout("full");
    check("full_first_rgb", (de_pix.size() > 0) ? de_pix[0] : 24'hx, 24'h000102);
    check("full_last_rgb", (de_pix.size() > 0) ? de_pix[de_pix.size()-1] : 24'hx, 24'h393A3B);

    // No resync: three bytes without a marker
    clear_mon();
    fd0 = m_fd;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hAA) b = 8'h55;
      send_byte(b);
    end
    repeat (60) @(negedge clk);
    check("noresync_frame_done", fd_cyc.size(), m_fd - fd0);
    check("noresync_de", de_pix.size(), 0);

    // Pre-sync garbage then a random frame
    clear_mon();
    rx0 = n_rx; fd0 = m_rx;
    send_byte(8'h55);
    send_byte(8'h12);
    send_byte(8'hAA);
    for (int i = 0; i < 3 * MEM; i++) send_byte(8'($urandom_range(0, 255)));
    check("garbage_rx_done_count", n_rx - rx0, m_rx - fd0);
    check_readout("garbage");

    // Framing error: a marker byte with a low stop bit must be dropped
    rx0 = n_rx;
    send_bits(8'hAA, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("framing_error_rx_done", n_rx - rx0, 0);

    // Camera mode: bytes are received but never assembled
    clear_mon();
    cam_mode = 1'b1;
    rx0 = n_rx; fd0 = m_rx;
    send_byte(8'hAA);
    for (int i = 0; i < 3 * MEM; i++) send_byte(8'($urandom_range(0, 255)));
    repeat (60) @(negedge clk);
    check("cam_rx_done_count", n_rx - rx0, m_rx - fd0);
    check("cam_frame_done", fd_cyc.size(), 0);
    check("cam_de", de_pix.size(), 0);
    cam_mode = 1'b0;

    // Reset mid-frame, then a full ramp frame from a clean pixel counter
    send_byte(8'hAA);
    for (int i = 0; i < 30; i++) send_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("midreset_outputs", {rx_done, frame_done, o_de, r_port, g_port, b_port}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    clear_mon();
    send_byte(8'hAA);
    for (int i = 0; i < 3 * MEM; i++) send_byte(8'(i));
    check_readout("after_reset");
    check("after_reset_first_rgb", (de_pix.size() > 0) ? de_pix[0] : 24'hx, 24'h000102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
